// File: rtl/conv1d_multich_engine.sv
// Multi-channel 1-D convolution engine: internal data/weight/result memories, sequential MAC datapath.
// Optional build macro CONV1D_RELU_EN clamps negative results to zero on store.
`default_nettype none

module conv1d_multich_engine #(
    parameter int DATA_WIDTH   = 8,
    parameter int ACCUM_WIDTH  = 24,
    parameter int INPUT_LEN    = 8,
    parameter int KERNEL_SIZE  = 3,
    parameter int STRIDE       = 1,
    parameter int NUM_CH       = 2,
    localparam int OUTPUT_LEN  = (INPUT_LEN - KERNEL_SIZE) / STRIDE + 1,
    localparam int NUM_WT      = NUM_CH * KERNEL_SIZE,
    localparam int NUM_RES     = NUM_CH * OUTPUT_LEN,
    localparam int DA_W        = (INPUT_LEN > 1) ? $clog2(INPUT_LEN) : 1,
    localparam int WA_W        = (NUM_WT > 1) ? $clog2(NUM_WT) : 1,
    localparam int RA_W        = (NUM_RES > 1) ? $clog2(NUM_RES) : 1
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   start,
    input  logic                   abort,
    output logic                   busy,
    output logic                   done,
    input  logic                   data_wen,
    input  logic [DA_W-1:0]        data_waddr,
    input  logic [DATA_WIDTH-1:0]  data_wdata,
    input  logic                   wt_wen,
    input  logic [WA_W-1:0]        wt_waddr,
    input  logic [DATA_WIDTH-1:0]  wt_wdata,
    input  logic [RA_W-1:0]        res_raddr,
    output logic [ACCUM_WIDTH-1:0] res_rdata
);

    localparam int CH_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
    localparam int O_W  = (OUTPUT_LEN > 1) ? $clog2(OUTPUT_LEN) : 1;
    localparam int K_W  = (KERNEL_SIZE > 1) ? $clog2(KERNEL_SIZE) : 1;

    localparam logic [CH_W-1:0] CH_LAST = CH_W'(NUM_CH - 1);
    localparam logic [O_W-1:0]  O_LAST  = O_W'(OUTPUT_LEN - 1);
    localparam logic [K_W-1:0]  K_LAST  = K_W'(KERNEL_SIZE - 1);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        FETCH = 3'd1,
        WAIT  = 3'd2,
        MAC   = 3'd3,
        STORE = 3'd4,
        DONE  = 3'd5
    } state_t;

    state_t                        state;
    logic [CH_W-1:0]               ch;
    logic [O_W-1:0]                o;
    logic [K_W-1:0]                k;
    logic signed [ACCUM_WIDTH-1:0] acc;

    logic signed [DATA_WIDTH-1:0]  data_mem [INPUT_LEN];
    logic signed [DATA_WIDTH-1:0]  wt_mem   [NUM_WT];
    logic [ACCUM_WIDTH-1:0]        res_mem  [NUM_RES];

    logic signed [DATA_WIDTH-1:0]  data_q;
    logic signed [DATA_WIDTH-1:0]  wt_q;

    logic [DA_W-1:0]               data_raddr;
    logic [WA_W-1:0]               wt_raddr;
    logic [RA_W-1:0]               res_waddr;
    logic signed [2*DATA_WIDTH-1:0] product;
    logic [ACCUM_WIDTH-1:0]        store_val;

    assign data_raddr = DA_W'(int'(o) * STRIDE + int'(k));
    assign wt_raddr   = WA_W'(int'(ch) * KERNEL_SIZE + int'(k));
    assign res_waddr  = RA_W'(int'(ch) * OUTPUT_LEN + int'(o));
    assign product    = data_q * wt_q;

`ifdef CONV1D_RELU_EN
    assign store_val = acc[ACCUM_WIDTH-1] ? '0 : acc;
`else
    assign store_val = acc;
`endif

    // Host writes only land while the engine is parked in IDLE.
    always_ff @(posedge clk) begin
        if (data_wen && state == IDLE && int'(data_waddr) < INPUT_LEN)
            data_mem[data_waddr] <= data_wdata;
        if (wt_wen && state == IDLE && int'(wt_waddr) < NUM_WT)
            wt_mem[wt_waddr] <= wt_wdata;
        if (state == FETCH) begin
            data_q <= data_mem[data_raddr];
            wt_q   <= wt_mem[wt_raddr];
        end
        if (state == STORE && !abort)
            res_mem[res_waddr] <= store_val;
    end

    assign res_rdata = (int'(res_raddr) < NUM_RES) ? res_mem[res_raddr] : '0;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            busy  <= 1'b0;
            done  <= 1'b0;
            acc   <= '0;
            ch    <= '0;
            o     <= '0;
            k     <= '0;
        end else begin
            done <= 1'b0;
            if (abort && state != IDLE) begin
                state <= IDLE;
                busy  <= 1'b0;
            end else begin
                case (state)
                    IDLE: begin
                        if (start) begin
                            acc   <= '0;
                            ch    <= '0;
                            o     <= '0;
                            k     <= '0;
                            state <= FETCH;
                            busy  <= 1'b1;
                        end
                    end
                    FETCH: state <= WAIT;
                    WAIT:  state <= MAC;
                    MAC: begin
                        acc <= acc + ACCUM_WIDTH'(product);
                        if (k == K_LAST) begin
                            state <= STORE;
                        end else begin
                            k     <= k + K_W'(1);
                            state <= FETCH;
                        end
                    end
                    STORE: begin
                        acc <= '0;
                        k   <= '0;
                        if (o == O_LAST) begin
                            o <= '0;
                            if (ch == CH_LAST) begin
                                state <= DONE;
                                done  <= 1'b1;
                            end else begin
                                ch    <= ch + CH_W'(1);
                                state <= FETCH;
                            end
                        end else begin
                            o     <= o + O_W'(1);
                            state <= FETCH;
                        end
                    end
                    DONE: begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end
                    default: begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule

`default_nettype wire

// File: doc/conv1d_multich_engine.md
CONV1D_MULTICH_ENGINE -- requirements
Module: conv1d_multich_engine

Interface
REQ-001 Parameters SHALL be as follows (name, default, meaning):
- DATA_WIDTH, 8: signed data and weight width.
- ACCUM_WIDTH, 24: signed accumulator and result width.
- INPUT_LEN, 8: input samples.
- KERNEL_SIZE, 3: taps per channel.
- STRIDE, 1: window step.
- NUM_CH, 2: output channels.
- OUTPUT_LEN: derived, (INPUT_LEN-KERNEL_SIZE)/STRIDE+1.

REQ-002 Ports SHALL be as follows (name, direction, width, meaning):
- clk, in, 1: clock, rising edge.
- rst_n, in, 1: reset, asynchronous, active-low.
- start, in, 1: start request.
- abort, in, 1: synchronous abort.
- busy, out, 1: engine running.
- done, out, 1: one-cycle completion pulse.
- data_wen, in, 1: data memory write enable.
- data_waddr, in, clog2(INPUT_LEN): data write address.
- data_wdata, in, DATA_WIDTH: data write value.
- wt_wen, in, 1: weight memory write enable.
- wt_waddr, in, clog2(NUM_CH*KERNEL_SIZE): weight address, ch*KERNEL_SIZE+k.
- wt_wdata, in, DATA_WIDTH: weight write value.
- res_raddr, in, clog2(NUM_CH*OUTPUT_LEN): result address, ch*OUTPUT_LEN+o.
- res_rdata, out, ACCUM_WIDTH: combinational result read.

Function
REQ-003 The data and weight memories SHALL be internal, with a synchronous write port and a synchronous read port of 1-cycle latency.
REQ-004 The state machine SHALL have the states IDLE, FETCH, WAIT, MAC, STORE and DONE.
REQ-005 In IDLE, start=1 SHALL clear the accumulator, set ch=0, o=0, k=0, and move to FETCH on the next cycle.
REQ-006 FETCH SHALL present data address o*STRIDE+k and weight address ch*KERNEL_SIZE+k, then go to WAIT.
REQ-007 WAIT SHALL go to MAC.
REQ-008 MAC SHALL perform acc <= acc + sign_extend(data*weight), with a signed 2*DATA_WIDTH product and wrap modulo 2^ACCUM_WIDTH.
- If k<KERNEL_SIZE-1: k++ and go to FETCH.
- Otherwise: go to STORE.
REQ-009 STORE SHALL write acc to result[ch*OUTPUT_LEN+o] and clear acc and k.
- Then o++; on wrap of o to 0, ch++.
- After the final (ch=NUM_CH-1, o=OUTPUT_LEN-1), go to DONE; otherwise go to FETCH.
REQ-010 DONE SHALL assert done for exactly one cycle, then go to IDLE.
REQ-011 Latency: done SHALL be high exactly 1+NUM_CH*OUTPUT_LEN*(3*KERNEL_SIZE+1) cycles after the cycle in which start was sampled.
REQ-012 busy SHALL be 1 in every state except IDLE; done SHALL never coincide with IDLE.
REQ-013 start SHALL be ignored while busy=1.
REQ-014 A start sampled in the same cycle the engine returns from DONE to IDLE SHALL not be accepted; start is accepted only when sampled in IDLE.
REQ-015 data_wen and wt_wen SHALL be ignored while busy=1; they SHALL take effect in IDLE.
REQ-016 When abort=1 in any non-IDLE state, the engine SHALL go to IDLE on the next edge with no done pulse.
- Results already stored SHALL be retained; results not yet stored SHALL be unchanged.
- abort SHALL take priority over all other transitions; abort in IDLE SHALL have no effect.
REQ-017 res_rdata SHALL reflect result[res_raddr] combinationally at all times; an out-of-range address SHALL return 0.

Reset
REQ-018 rst_n=0 SHALL force state=IDLE, busy=0, done=0, acc=0, ch=0, o=0, k=0 asynchronously, including in the middle of an operation.
REQ-019 Memory contents (data, weight, result) SHALL NOT be reset and SHALL be undefined until written.

Configuration
REQ-020 With CONV1D_RELU_EN defined, STORE SHALL write 0 when acc is negative (MSB=1), and acc otherwise.
REQ-021 Without CONV1D_RELU_EN, STORE SHALL write acc unmodified, and no ReLU logic SHALL be present.

Verification
REQ-022 Basic run: defaults, data=1..8, ch0 weights {1,1,1}, ch1 weights {1,0,-1}, start.
- ch0 SHALL read 6,9,12,15,18,21.
- ch1 SHALL read -2 at all six addresses (0 for ch1 with CONV1D_RELU_EN).
- done SHALL pulse 121 cycles after start.
REQ-023 Stride: STRIDE=2, same data, ch0 weights {1,1,1}.
- OUTPUT_LEN=3; ch0 SHALL read 6,12,18.
- done SHALL pulse 1+2*3*10=61 cycles after start.
REQ-024 Signed extreme: all data=-128, all weights=-128.
- Every result SHALL read 49152; busy SHALL be high throughout.
REQ-025 Busy protection: start pulsed and data_wen=1 (addr 0, value 99) issued mid-run.
- Exactly one done pulse SHALL occur.
- A subsequent run SHALL use the original data[0].
REQ-026 Abort and reset:
- abort asserted 20 cycles after start: busy SHALL drop next cycle, with no done pulse; result[0] SHALL already hold 6 and a restart SHALL reproduce REQ-022.
- rst_n=0 mid-run: busy=0 and done=0 immediately.
